// File: rtl/display_count_controller.sv
// Two-digit BCD counter driven by four debounced keys (inc, dec, clear, lock)
// with hold-to-auto-repeat, carry/borrow between digits and optional wrap.
module display_count_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit WRAP_EN         = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Digit_Tens,
  output logic [3:0] o_Digit_Ones,
  output logic       o_Update,
  output logic       o_Wrap,
  output logic       o_Locked
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  localparam int INC = 0;
  localparam int DEC = 1;
  localparam int CLR = 2;
  localparam int LCK = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    stable;
  logic [3:0]    stable_d;
  logic [3:0]    press;
  logic [DW-1:0] db_cnt [4];
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          dir;
  logic          dir_next;
  logic          step;
  logic          step_up;
  logic          held;

  assign raw  = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  // dir=1 means the increment key owns the repeat
  assign held = dir ? stable[INC] : stable[DEC];

  // Per-key debounce filter and registered rising-edge press pulses
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stable   <= 4'b0000;
      stable_d <= 4'b0000;
      press    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= {DW{1'b0}};
      end
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= {DW{1'b0}};
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= {DW{1'b0}};
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Repeat FSM state, timer and latched direction
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      timer <= {TW{1'b0}};
      dir   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      dir   <= dir_next;
    end
  end

  // Next-state and step decision; clear and a locking press abort any repeat
  always_comb begin
    state_next = state;
    timer_next = timer;
    dir_next   = dir;
    step       = 1'b0;
    step_up    = dir;
    if (press[CLR]) begin
      state_next = IDLE;
      timer_next = {TW{1'b0}};
    end else if (press[LCK] && !o_Locked) begin
      state_next = IDLE;
      timer_next = {TW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (!o_Locked && press[INC] && !press[DEC]) begin
            step       = 1'b1;
            step_up    = 1'b1;
            dir_next   = 1'b1;
            state_next = DELAY;
            timer_next = {TW{1'b0}};
          end else if (!o_Locked && press[DEC] && !press[INC]) begin
            step       = 1'b1;
            step_up    = 1'b0;
            dir_next   = 1'b0;
            state_next = DELAY;
            timer_next = {TW{1'b0}};
          end else begin
            state_next = IDLE;
          end
        end
        DELAY: begin
          if (!held) begin
            state_next = IDLE;
            timer_next = {TW{1'b0}};
          end else if (timer == DLY_LAST) begin
            step       = 1'b1;
            state_next = REPEAT;
            timer_next = {TW{1'b0}};
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            state_next = IDLE;
            timer_next = {TW{1'b0}};
          end else if (timer == PER_LAST) begin
            step       = 1'b1;
            timer_next = {TW{1'b0}};
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = {TW{1'b0}};
        end
      endcase
    end
  end

  // BCD count, lock flag and the update/wrap pulses aligned with digit changes
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Digit_Tens <= 4'd0;
      o_Digit_Ones <= 4'd0;
      o_Update     <= 1'b0;
      o_Wrap       <= 1'b0;
      o_Locked     <= 1'b0;
    end else begin
      o_Update <= 1'b0;
      o_Wrap   <= 1'b0;
      if (press[LCK]) begin
        o_Locked <= ~o_Locked;
      end else begin
        o_Locked <= o_Locked;
      end
      if (press[CLR]) begin
        o_Digit_Tens <= 4'd0;
        o_Digit_Ones <= 4'd0;
        o_Update     <= (o_Digit_Tens != 4'd0) || (o_Digit_Ones != 4'd0);
      end else if (step && step_up) begin
        if (o_Digit_Ones != 4'd9) begin
          o_Digit_Ones <= o_Digit_Ones + 4'd1;
          o_Update     <= 1'b1;
        end else if (o_Digit_Tens != 4'd9) begin
          o_Digit_Ones <= 4'd0;
          o_Digit_Tens <= o_Digit_Tens + 4'd1;
          o_Update     <= 1'b1;
        end else if (WRAP_EN) begin
          o_Digit_Ones <= 4'd0;
          o_Digit_Tens <= 4'd0;
          o_Update     <= 1'b1;
          o_Wrap       <= 1'b1;
        end else begin
          o_Update <= 1'b0;
        end
      end else if (step) begin
        if (o_Digit_Ones != 4'd0) begin
          o_Digit_Ones <= o_Digit_Ones - 4'd1;
          o_Update     <= 1'b1;
        end else if (o_Digit_Tens != 4'd0) begin
          o_Digit_Ones <= 4'd9;
          o_Digit_Tens <= o_Digit_Tens - 4'd1;
          o_Update     <= 1'b1;
        end else if (WRAP_EN) begin
          o_Digit_Ones <= 4'd9;
          o_Digit_Tens <= 4'd9;
          o_Update     <= 1'b1;
          o_Wrap       <= 1'b1;
        end else begin
          o_Update <= 1'b0;
        end
      end else begin
        o_Update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_count_controller.sv
// Bench for display_count_controller: directed plan steps plus random key
// activity, both checked every cycle against an integer-count reference model.
module tb_display_count_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic       upd0, wrap0, lock0, upd1, wrap1, lock1;
  int         compared   = 0;
  int         mismatched = 0;

  // Reference model state (index 0: wrapping instance, 1: saturating instance)
  bit [3:0] m_stable, m_rose, m_press;
  int       m_run [4];
  int       m_cyc;
  int       m_count [2];
  bit       m_locked [2];
  bit       m_active [2];
  bit       m_dir [2];
  int       m_t0 [2];
  bit       m_upd [2];
  bit       m_wrap [2];

  always #5 clk = ~clk;

  display_count_controller #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP_EN(1'b1)
  ) dut_wrap (
    .i_Clk(clk), .i_Reset(rst),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_Digit_Tens(tens0), .o_Digit_Ones(ones0),
    .o_Update(upd0), .o_Wrap(wrap0), .o_Locked(lock0)
  );

  display_count_controller #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP_EN(1'b0)
  ) dut_sat (
    .i_Clk(clk), .i_Reset(rst),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_Digit_Tens(tens1), .o_Digit_Ones(ones1),
    .o_Update(upd1), .o_Wrap(wrap1), .o_Locked(lock1)
  );

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_step_count(input int k, input bit up);
    if (up) begin
      if (m_count[k] < 99) begin
        m_count[k]++;
        m_upd[k] = 1'b1;
      end else if (k == 0) begin
        m_count[k] = 0;
        m_upd[k]   = 1'b1;
        m_wrap[k]  = 1'b1;
      end
    end else begin
      if (m_count[k] > 0) begin
        m_count[k]--;
        m_upd[k] = 1'b1;
      end else if (k == 0) begin
        m_count[k] = 99;
        m_upd[k]   = 1'b1;
        m_wrap[k]  = 1'b1;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled
  task automatic model_edge();
    bit lock_old;
    bit held;
    int e;
    if (rst) begin
      m_stable = 4'b0000;
      m_rose   = 4'b0000;
      m_press  = 4'b0000;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      for (int k = 0; k < 2; k++) begin
        m_count[k]  = 0;
        m_locked[k] = 1'b0;
        m_active[k] = 1'b0;
        m_dir[k]    = 1'b0;
        m_upd[k]    = 1'b0;
        m_wrap[k]   = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_upd[k]  = 1'b0;
        m_wrap[k] = 1'b0;
        lock_old  = m_locked[k];
        if (m_press[3]) m_locked[k] = !m_locked[k];
        if (m_press[2]) begin
          if (m_count[k] != 0) m_upd[k] = 1'b1;
          m_count[k]  = 0;
          m_active[k] = 1'b0;
        end else if (m_press[3] && !lock_old) begin
          m_active[k] = 1'b0;
        end else if (!m_active[k]) begin
          if (!lock_old && (m_press[0] != m_press[1])) begin
            m_dir[k]    = m_press[0];
            m_active[k] = 1'b1;
            m_t0[k]     = m_cyc;
            m_step_count(k, m_press[0]);
          end
        end else begin
          held = m_dir[k] ? m_stable[0] : m_stable[1];
          e    = m_cyc - m_t0[k];
          if (!held) m_active[k] = 1'b0;
          else if (e == RD || (e > RD && (e - RD) % RP == 0)) m_step_count(k, m_dir[k]);
        end
      end
      m_press = m_rose;
      m_rose  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (sw[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = !m_stable[i];
            m_run[i]    = 0;
            if (m_stable[i]) m_rose[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_wrap", {tens0, ones0, upd0, wrap0, lock0},
          {4'(m_count[0] / 10), 4'(m_count[0] % 10), m_upd[0], m_wrap[0], m_locked[0]});
    check("model_sat", {tens1, ones1, upd1, wrap1, lock1},
          {4'(m_count[1] / 10), 4'(m_count[1] % 10), m_upd[1], m_wrap[1], m_locked[1]});
  endtask

  task automatic expect0(input string tag, input int val, input bit u, input bit w, input bit l);
    check(tag, {tens0, ones0, upd0, wrap0, lock0}, {4'(val / 10), 4'(val % 10), u, w, l});
  endtask

  // Hold keys for 8 cycles (checking the digit edge at +6), then release
  task automatic tap_expect(input logic [3:0] keys, input string tag,
                            input int val, input bit u, input bit w, input bit l);
    sw = keys;
    repeat (6) tick();
    expect0(tag, val, u, w, l);
    repeat (2) tick();
    sw = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic tap_quiet(input logic [3:0] keys);
    sw = keys;
    repeat (8) tick();
    sw = 4'b0000;
    repeat (10) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int r;
    int hold;
    m_cyc = 0;
    rst   = 1'b1;
    sw    = 4'b0000;
    repeat (2) tick();
    expect0("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Tap and short glitch
    sw = 4'b0001;
    repeat (5) tick();
    expect0("tap_early", 0, 1'b0, 1'b0, 1'b0);
    tick();
    expect0("tap", 1, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    sw = 4'b0000;
    repeat (10) tick();
    sw = 4'b0001;
    repeat (3) tick();
    sw = 4'b0000;
    repeat (10) tick();
    expect0("glitch", 1, 1'b0, 1'b0, 1'b0);

    // Hold from 09 with auto-repeat
    repeat (8) tap_quiet(4'b0001);
    expect0("at09", 9, 1'b0, 1'b0, 1'b0);
    sw = 4'b0001;
    repeat (6) tick();
    expect0("hold_t0", 10, 1'b1, 1'b0, 1'b0);
    repeat (19) tick();
    expect0("hold_pre", 10, 1'b0, 1'b0, 1'b0);
    tick();
    expect0("hold_t20", 11, 1'b1, 1'b0, 1'b0);
    for (int n = 12; n <= 14; n++) begin
      repeat (4) tick();
      expect0("hold_gap", n - 1, 1'b0, 1'b0, 1'b0);
      tick();
      expect0("hold_rep", n, 1'b1, 1'b0, 1'b0);
    end
    sw = 4'b0000;
    repeat (30) tick();
    expect0("release", 14, 1'b0, 1'b0, 1'b0);

    // Wrap and saturation
    tap_expect(4'b0100, "clear", 0, 1'b1, 1'b0, 1'b0);
    sw = 4'b0010;
    repeat (6) tick();
    expect0("wrap_dn", 99, 1'b1, 1'b1, 1'b0);
    check("sat_dn", {tens1, ones1, upd1, wrap1, lock1}, 11'd0);
    repeat (2) tick();
    sw = 4'b0000;
    repeat (10) tick();
    tap_expect(4'b0001, "wrap_up", 0, 1'b1, 1'b1, 1'b0);

    // Simultaneous events
    tap_expect(4'b0100, "clr_zero", 0, 1'b0, 1'b0, 1'b0);
    repeat (5) tap_quiet(4'b0001);
    tap_expect(4'b0101, "inc_clr", 0, 1'b1, 1'b0, 1'b0);
    repeat (5) tap_quiet(4'b0001);
    tap_expect(4'b0011, "inc_dec", 5, 1'b0, 1'b0, 1'b0);
    sw = 4'b0001;
    repeat (6) tick();
    expect0("rep_start", 6, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    sw = 4'b0011;
    repeat (8) tick();
    sw = 4'b0001;
    repeat (9) tick();
    expect0("dec_ignored", 7, 1'b1, 1'b0, 1'b0);
    sw = 4'b0000;
    repeat (12) tick();
    expect0("rel_rep", 7, 1'b0, 1'b0, 1'b0);

    // Lock
    tap_expect(4'b1000, "lock_on", 7, 1'b0, 1'b0, 1'b1);
    tap_expect(4'b0001, "locked_inc", 7, 1'b0, 1'b0, 1'b1);
    tap_expect(4'b0100, "locked_clr", 0, 1'b1, 1'b0, 1'b1);
    tap_expect(4'b1000, "lock_off", 0, 1'b0, 1'b0, 1'b0);
    tap_expect(4'b0001, "resume", 1, 1'b1, 1'b0, 1'b0);

    // Reset during repeat at 42, key still held afterwards
    sw    = 4'b0001;
    guard = 0;
    while (m_count[0] != 42 && guard < 400) begin
      tick();
      guard++;
    end
    expect0("at42", 42, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    expect0("mid_reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    expect0("post_rst_wait", 0, 1'b0, 1'b0, 1'b0);
    tick();
    expect0("post_rst_press", 1, 1'b1, 1'b0, 1'b0);
    sw = 4'b0000;
    repeat (10) tick();

    // Randomized key activity against the model
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      sw = 4'b0001;
      else if (r < 70) sw = 4'b0010;
      else if (r < 78) sw = 4'b0100;
      else if (r < 84) sw = 4'b1000;
      else if (r < 90) sw = 4'b0011;
      else if (r < 97) sw = 4'($urandom_range(0, 15));
      else begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      hold = $urandom_range(1, 60);
      repeat (hold) tick();
      if ($urandom_range(0, 1) == 0) begin
        sw = 4'b0000;
        repeat ($urandom_range(1, 12)) tick();
      end
    end
    sw = 4'b0000;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_count_controller.md
Name: display_count_controller

Overview:
Controller that sequences the two-digit seven-segment display path on the board. It debounces the four raw switches and converts them into increment, decrement, clear and lock commands, with hold-to-auto-repeat. It maintains a decimal count 00-99 and presents tens/ones digits to the downstream per-digit segment decoders. It replaces per-digit independent counting with one coordinated two-digit counter that has carry and borrow between digits.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a raw switch must differ from its debounced state before the debounced state flips (10 ms at 25 MHz).
REPEAT_DELAY, 12500000, cycles between the first step and the first auto-repeat step while a key is held.
REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat steps.
WRAP_EN, 1, 1: count wraps 99<->00; 0: count saturates at 99 and at 00.

Ports:
i_Clk  input  1  system clock, single clock domain
i_Reset  input  1  synchronous reset, active-high
i_Switch_1  input  1  raw increment key
i_Switch_2  input  1  raw decrement key
i_Switch_3  input  1  raw clear key
i_Switch_4  input  1  raw lock-toggle key
o_Digit_Tens  output  4  BCD tens digit, 0-9
o_Digit_Ones  output  4  BCD ones digit, 0-9
o_Update  output  1  one-cycle pulse when the digits change
o_Wrap  output  1  one-cycle pulse on a 99->00 or 00->99 transition
o_Locked  output  1  lock state; inc/dec are suppressed while 1

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge): all outputs 0, debounced states 0, debounce counters 0, FSM IDLE, timers 0. Reset overrides every other event, including reset during debounce or auto-repeat.
- Debounce, per switch: a counter increments while raw != stable and clears when raw == stable. When the counter reaches DEBOUNCE_CYCLES, stable flips and the counter clears. A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: rising edge of a debounced signal, registered as a one-cycle pulse on the edge after the stable flip.
- Latency: raw rise held steady, then the digit update and o_Update occur DEBOUNCE_CYCLES+2 edges after the raw rise.
- Repeat FSM, shared by inc/dec, with states IDLE, DELAY, REPEAT and a stored direction:
  - IDLE: if inc press only (and unlocked): step +1, latch dir=up, go to DELAY. If dec press only: step -1, latch dir=down, go to DELAY. If both press in the same cycle: no step, stay IDLE.
  - DELAY: timer counts to REPEAT_DELAY. If the latched key's debounced level is 0, go to IDLE. On expiry: step, go to REPEAT.
  - REPEAT: a step every REPEAT_PERIOD cycles. On release of the latched key, go to IDLE.
  - In DELAY/REPEAT, presses of the opposite key are ignored.
- Arithmetic (BCD):
  - +1: ones 9->0 with carry into tens. At 99: with WRAP_EN=1 go to 00 and pulse o_Wrap; with WRAP_EN=0 hold at 99.
  - -1: ones 0->9 with borrow from tens. At 00: with WRAP_EN=1 go to 99 and pulse o_Wrap; with WRAP_EN=0 hold at 00.
  - Saturated hold produces no o_Update.
- Clear press: digits become 00 on the next edge and the FSM goes to IDLE. Clear has priority over a step in the same cycle. o_Update pulses only if the count was nonzero. Clear works while locked.
- Lock press: toggles o_Locked. Lock going to 1 forces the FSM to IDLE. Inc/dec presses are ignored while locked.
- o_Update and o_Wrap are registered and aligned with the digit change. Both are 0 in every other cycle.

Test Plan:
(Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, WRAP_EN=1 unless noted.)
1. Tap: from reset, i_Switch_1 high 8 cycles -> digits go 00->01 exactly 6 edges after the raw rise, with one o_Update pulse. A 3-cycle pulse on i_Switch_1 -> no change.
2. Hold at count 09: i_Switch_1 held; first step at t0 -> steps at t0, t0+20, t0+25, t0+30, t0+35 give 10, 11, 12, 13, 14. Release -> FSM IDLE, no further steps.
3. Wrap: at 00, tap i_Switch_2 -> 99 with o_Wrap=1 for one cycle. Tap i_Switch_1 -> 00 with o_Wrap. With WRAP_EN=0: decrement at 00 -> stays 00, o_Update=0.
4. Simultaneous events at count 05: i_Switch_1 and i_Switch_3 rise together -> 00. i_Switch_1 and i_Switch_2 rise together -> stays 05, no o_Update. A dec press during an inc repeat -> ignored.
5. Lock: tap i_Switch_4 -> o_Locked=1. Tap i_Switch_1 -> no change. Tap i_Switch_3 at 07 -> 00. Tap i_Switch_4 -> o_Locked=0, increments resume.
6. Reset mid-operation: assert i_Reset for 1 cycle during REPEAT at 42 -> digits 00, all outputs 0, FSM IDLE. A key still held after reset needs a full DEBOUNCE_CYCLES before producing a press.
